// File: rtl/int_tx_ascii.sv
// Renders a captured ALU result as an ASCII decimal or hex string, optionally followed by CR LF,
// and pushes it into the UART TX FIFO one character per cycle.
module int_tx_ascii #(
    parameter int DATA_W         = 8,
    parameter int DEC_DIGITS     = 3,
    parameter int HEX_DIGITS     = 2,
    parameter int APPEND_CRLF    = 1,
    parameter int SUPPRESS_ZEROS = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              enviar,
    input  logic              modo_hex,
    input  logic [DATA_W-1:0] DATO_ALU,
    input  logic              fifo_full,
    output logic              WR_FIFO,
    output logic [7:0]        data_fifo,
    output logic              busy,
    output logic              done
);

    function automatic int dec_needed(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        do begin
            v = v / 64'd10;
            n++;
        end while (v != 64'd0);
        return n;
    endfunction

    localparam int BCD_W = 4 * DEC_DIGITS;
    localparam int HEX_W = 4 * HEX_DIGITS;
    localparam int MAX_D = (DEC_DIGITS > HEX_DIGITS) ? DEC_DIGITS : HEX_DIGITS;
    localparam int IDX_W = $clog2(MAX_D) + 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    if (DATA_W < 4 || DATA_W > 32) begin : g_bad_width
        $error("int_tx_ascii: DATA_W must be within 4..32");
    end
    if (DEC_DIGITS < dec_needed(DATA_W)) begin : g_bad_dec
        $error("int_tx_ascii: DEC_DIGITS too small for DATA_W");
    end
    if (HEX_DIGITS != (DATA_W + 3) / 4) begin : g_bad_hex
        $error("int_tx_ascii: HEX_DIGITS must equal ceil(DATA_W/4)");
    end

    typedef enum logic [2:0] {IDLE, CONV, EMIT, TAIL, FIN} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  value;
    logic [BCD_W-1:0]   bcd, bcd_adj, bcd_next;
    logic               hex;
    logic [IDX_W-1:0]   idx, idx_m1;
    logic [CNT_W-1:0]   cnt;
    logic               seen;
    logic               lf;
    logic [HEX_W-1:0]   hex_src, din_hex;
    logic [3:0]         cur_nib, nxt_nib;
    logic               last, skip, advance;

    function automatic logic [7:0] ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign hex_src = HEX_W'(value);
    assign din_hex = HEX_W'(DATO_ALU);
    assign idx_m1  = idx - 1'b1;
    assign last    = (idx == '0);

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < DEC_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], value[DATA_W-1]};
    end

    always_comb begin
        cur_nib = hex ? 4'(hex_src >> {idx, 2'b00})    : 4'(bcd >> {idx, 2'b00});
        nxt_nib = hex ? 4'(hex_src >> {idx_m1, 2'b00}) : 4'(bcd >> {idx_m1, 2'b00});
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        WR_FIFO   = 1'b0;
        skip      = 1'b0;
        advance   = 1'b0;
        busy      = (state != IDLE);
        done      = (state == FIN);
        case (state)
            IDLE: if (enviar) state_nxt = modo_hex ? EMIT : CONV;
            CONV: if (cnt == CNT_W'(DATA_W - 1)) state_nxt = EMIT;
            EMIT: begin
                // A suppressed leading zero consumes its slot without looking at fifo_full.
                skip    = !hex && (SUPPRESS_ZEROS != 0) && (cur_nib == 4'd0) && !seen && !last;
                WR_FIFO = !skip && !fifo_full;
                advance = skip || !fifo_full;
                if (advance && last) state_nxt = (APPEND_CRLF != 0) ? TAIL : FIN;
            end
            TAIL: begin
                WR_FIFO = !fifo_full;
                if (!fifo_full && lf) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // data_fifo always holds the character of the slot being presented, so it is
    // loaded on the edge that moves to that slot.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            value     <= '0;
            bcd       <= '0;
            hex       <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            seen      <= 1'b0;
            lf        <= 1'b0;
            data_fifo <= 8'h00;
        end else begin
            case (state)
                IDLE: if (enviar) begin
                    value <= DATO_ALU;
                    hex   <= modo_hex;
                    bcd   <= '0;
                    cnt   <= '0;
                    seen  <= 1'b0;
                    lf    <= 1'b0;
                    if (modo_hex) begin
                        idx       <= IDX_W'(HEX_DIGITS - 1);
                        data_fifo <= ascii(din_hex[HEX_W-1 -: 4]);
                    end
                end
                CONV: begin
                    bcd   <= bcd_next;
                    value <= value << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        idx       <= IDX_W'(DEC_DIGITS - 1);
                        data_fifo <= ascii(bcd_next[BCD_W-1 -: 4]);
                    end
                end
                EMIT: if (advance) begin
                    if (!skip) seen <= 1'b1;
                    if (!last) begin
                        idx       <= idx_m1;
                        data_fifo <= ascii(nxt_nib);
                    end else if (APPEND_CRLF != 0) begin
                        data_fifo <= 8'h0D;
                    end
                end
                TAIL: if (!fifo_full && !lf) begin
                    lf        <= 1'b1;
                    data_fifo <= 8'h0A;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_tx_ascii.sv
// Bench for int_tx_ascii: three configurations share one stimulus stream and every
// written string is compared against a digit-arithmetic reference model.
module tb_int_tx_ascii;

    logic        CLK, RESET_N, enviar, modo_hex, fifo_full;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic        wr[3];
    logic [7:0]  df[3];
    logic        busy_v[3], done_v[3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int viol     = 0;

    byte unsigned q[3][$];
    int           t[3][$];
    int           dn[3][$];
    byte unsigned e[3][$];
    int           skip0;

    int_tx_ascii u0 (
        .CLK(CLK), .RESET_N(RESET_N), .enviar(enviar), .modo_hex(modo_hex), .DATO_ALU(d8),
        .fifo_full(fifo_full), .WR_FIFO(wr[0]), .data_fifo(df[0]), .busy(busy_v[0]), .done(done_v[0])
    );
    int_tx_ascii #(.SUPPRESS_ZEROS(0)) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .enviar(enviar), .modo_hex(modo_hex), .DATO_ALU(d8),
        .fifo_full(fifo_full), .WR_FIFO(wr[1]), .data_fifo(df[1]), .busy(busy_v[1]), .done(done_v[1])
    );
    int_tx_ascii #(.DATA_W(16), .DEC_DIGITS(5), .HEX_DIGITS(4)) u2 (
        .CLK(CLK), .RESET_N(RESET_N), .enviar(enviar), .modo_hex(modo_hex), .DATO_ALU(d16),
        .fifo_full(fifo_full), .WR_FIFO(wr[2]), .data_fifo(df[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (wr[i]) begin
                q[i].push_back(df[i]);
                t[i].push_back(cyc);
                if (fifo_full) viol++;
            end
            if (done_v[i]) dn[i].push_back(cyc);
        end
    end

    function automatic byte unsigned chr(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    // Reference: digits by repeated division, printed most significant first.
    function automatic void model(input longint unsigned v, input bit h, input int dd, input int hd,
                                  input bit sup, output byte unsigned s[$], output int skips);
        int  dig[8];
        bit  lead;
        longint unsigned x;
        s = {};
        skips = 0;
        if (h) begin
            for (int i = hd - 1; i >= 0; i--) s.push_back(chr(int'((v >> (4 * i)) & 64'd15)));
        end else begin
            x = v;
            for (int i = 0; i < dd; i++) begin
                dig[i] = int'(x % 64'd10);
                x = x / 64'd10;
            end
            lead = 1'b1;
            for (int i = dd - 1; i >= 0; i--) begin
                if (sup && lead && dig[i] == 0 && i != 0) skips++;
                else begin
                    lead = 1'b0;
                    s.push_back(chr(dig[i]));
                end
            end
        end
        s.push_back(8'h0D);
        s.push_back(8'h0A);
    endfunction

    function automatic logic [135:0] pack(input byte unsigned s[$]);
        logic [135:0] r;
        r = '0;
        r[135:128] = 8'(s.size());
        for (int i = 0; i < s.size() && i < 16; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            t[i].delete();
            dn[i].delete();
        end
    endtask

    task automatic expect_all(input logic [7:0] a, input logic [15:0] b, input bit h);
        int s1, s2;
        model(longint'(a), h, 3, 2, 1'b1, e[0], skip0);
        model(longint'(a), h, 3, 2, 1'b0, e[1], s1);
        model(longint'(b), h, 5, 4, 1'b1, e[2], s2);
    endtask

    task automatic send(input logic [7:0] a, input logic [15:0] b, input logic h, output int k);
        @(posedge CLK); #1;
        d8 = a; d16 = b; modo_hex = h; enviar = 1'b1;
        @(posedge CLK); #1;
        k = cyc;
        enviar = 1'b0;
    endtask

    task automatic wait_done(input int mode, output bit to);
        to = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(posedge CLK); #1;
            if (dn[0].size() > 0 && dn[1].size() > 0 && dn[2].size() > 0) begin
                to = 1'b0;
                break;
            end
            fifo_full = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 2) ? ~fifo_full : 1'b0;
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; enviar = 1'b0; modo_hex = 1'b0; fifo_full = 1'b0; d8 = '0; d16 = '0;
        repeat (3) @(posedge CLK);
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({wr[i], df[i], busy_v[i], done_v[i]} !== 11'd0) begin
                failures++;
                $display("FAIL reset_outputs inst%0d got=%b exp=0", i, {wr[i], df[i], busy_v[i], done_v[i]});
            end
        end
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_decimal();
        logic [7:0] vals[3] = '{8'd200, 8'd7, 8'd0};
        int k, first, lastw;
        bit to;
        for (int v = 0; v < 3; v++) begin
            clear_logs();
            d16 = 16'($urandom);
            expect_all(vals[v], d16, 1'b0);
            send(vals[v], d16, 1'b0, k);
            wait_done(0, to);
            checks++;
            if (to) begin failures++; $display("FAIL dec_timeout value=%0d got=timeout exp=done", vals[v]); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pack(q[i]) !== pack(e[i])) begin
                    failures++;
                    $display("FAIL dec_string inst%0d got=%h exp=%h", i, pack(q[i]), pack(e[i]));
                end
            end
            first = (q[0].size() > 0) ? t[0][0] : -1;
            lastw = (q[0].size() > 0) ? t[0][$] : -1;
            checks++;
            if (first !== k + 8 + skip0) begin
                failures++;
                $display("FAIL dec_first_write value=%0d got=%0d exp=%0d", vals[v], first, k + 8 + skip0);
            end
            checks++;
            if (lastw - first !== q[0].size() - 1) begin
                failures++;
                $display("FAIL dec_consecutive value=%0d got=%0d exp=%0d", vals[v], lastw - first, q[0].size() - 1);
            end
            checks++;
            if (dn[0].size() != 1 || dn[0][0] !== lastw + 1) begin
                failures++;
                $display("FAIL dec_done value=%0d got=%0d exp=%0d", vals[v], dn[0].size() > 0 ? dn[0][0] : -1, lastw + 1);
            end
            checks++;
            if ({busy_v[0], busy_v[1], busy_v[2]} !== 3'b000) begin
                failures++;
                $display("FAIL dec_busy_after got=%b exp=000", {busy_v[0], busy_v[1], busy_v[2]});
            end
        end
    endtask

    task automatic test_hex();
        logic [7:0] vals[2] = '{8'hAF, 8'h0A};
        int k, first;
        bit to;
        for (int v = 0; v < 2; v++) begin
            clear_logs();
            d16 = 16'($urandom);
            expect_all(vals[v], d16, 1'b1);
            send(vals[v], d16, 1'b1, k);
            wait_done(0, to);
            checks++;
            if (to) begin failures++; $display("FAIL hex_timeout got=timeout exp=done"); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pack(q[i]) !== pack(e[i])) begin
                    failures++;
                    $display("FAIL hex_string inst%0d got=%h exp=%h", i, pack(q[i]), pack(e[i]));
                end
            end
            first = (q[0].size() > 0) ? t[0][0] : -1;
            checks++;
            if (first !== k) begin
                failures++;
                $display("FAIL hex_first_write value=%h got=%0d exp=%0d", vals[v], first, k);
            end
        end
    endtask

    task automatic test_stall();
        int k;
        bit to;
        clear_logs();
        d16 = 16'($urandom);
        expect_all(8'd255, d16, 1'b0);
        send(8'd255, d16, 1'b0, k);
        for (int n = 0; n < 100; n++) begin
            @(posedge CLK); #1;
            if (q[0].size() >= 1) break;
        end
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if ({wr[0], df[0]} !== {1'b0, 8'h35}) begin
                failures++;
                $display("FAIL stall_hold got=%b/%h exp=0/35", wr[0], df[0]);
            end
            @(posedge CLK); #1;
        end
        fifo_full = 1'b0;
        wait_done(0, to);
        checks++;
        if (to) begin failures++; $display("FAIL stall_timeout got=timeout exp=done"); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pack(q[i]) !== pack(e[i])) begin
                failures++;
                $display("FAIL stall_string inst%0d got=%h exp=%h", i, pack(q[i]), pack(e[i]));
            end
        end
        for (int m = 1; m <= 2; m++) begin
            for (int r = 0; r < 6; r++) begin
                clear_logs();
                d8 = 8'($urandom); d16 = 16'($urandom);
                modo_hex = 1'($urandom_range(0, 1));
                expect_all(d8, d16, modo_hex);
                send(d8, d16, modo_hex, k);
                wait_done(m, to);
                checks++;
                if (to) begin failures++; $display("FAIL stall_rand_timeout mode=%0d got=timeout exp=done", m); end
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (pack(q[i]) !== pack(e[i])) begin
                        failures++;
                        $display("FAIL stall_rand_string mode=%0d inst%0d got=%h exp=%h", m, i, pack(q[i]), pack(e[i]));
                    end
                end
            end
        end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL write_while_full got=%0d exp=0", viol); end
    endtask

    task automatic test_enviar_ignored();
        int k;
        bit to;
        clear_logs();
        d16 = 16'($urandom);
        expect_all(8'hAF, d16, 1'b1);
        send(8'hAF, d16, 1'b1, k);
        d8 = 8'h12; enviar = 1'b1;
        @(posedge CLK); #1;
        enviar = 1'b0;
        to = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (done_v[0]) begin to = 1'b0; break; end
        end
        enviar = 1'b1;
        @(posedge CLK); #1;
        enviar = 1'b0;
        checks++;
        if (to) begin failures++; $display("FAIL fin_timeout got=timeout exp=done"); end
        wait_done(0, to);
        repeat (20) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pack(q[i]) !== pack(e[i]) || dn[i].size() != 1 || busy_v[i] !== 1'b0) begin
                failures++;
                $display("FAIL ignore_string inst%0d got=%h/%0d exp=%h/1", i, pack(q[i]), dn[i].size(), pack(e[i]));
            end
        end
        clear_logs();
        d16 = 16'($urandom);
        expect_all(8'h3C, d16, 1'b1);
        send(8'h3C, d16, 1'b1, k);
        wait_done(0, to);
        checks++;
        if (to || pack(q[0]) !== pack(e[0])) begin
            failures++;
            $display("FAIL restart_string got=%h exp=%h", pack(q[0]), pack(e[0]));
        end
    endtask

    task automatic test_wide();
        int k;
        bit to;
        logic [15:0] vals[3] = '{16'd65535, 16'd0, 16'd10000};
        for (int v = 0; v < 3; v++) begin
            clear_logs();
            d8 = 8'($urandom);
            expect_all(d8, vals[v], 1'b0);
            send(d8, vals[v], 1'b0, k);
            wait_done(0, to);
            checks++;
            if (to || pack(q[2]) !== pack(e[2])) begin
                failures++;
                $display("FAIL wide_string value=%0d got=%h exp=%h", vals[v], pack(q[2]), pack(e[2]));
            end
        end
    endtask

    task automatic test_random();
        int k;
        bit to;
        for (int r = 0; r < 20; r++) begin
            clear_logs();
            d8 = 8'($urandom); d16 = 16'($urandom);
            modo_hex = 1'($urandom_range(0, 1));
            expect_all(d8, d16, modo_hex);
            send(d8, d16, modo_hex, k);
            wait_done(int'($urandom_range(0, 2)), to);
            checks++;
            if (to) begin failures++; $display("FAIL rand_timeout iter=%0d got=timeout exp=done", r); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pack(q[i]) !== pack(e[i])) begin
                    failures++;
                    $display("FAIL rand_string iter=%0d inst%0d got=%h exp=%h", r, i, pack(q[i]), pack(e[i]));
                end
            end
        end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL rand_write_while_full got=%0d exp=0", viol); end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_logs();
        send(8'd200, 16'd40000, 1'b0, k);
        for (int n = 0; n < 100; n++) begin
            @(posedge CLK); #1;
            if (q[0].size() >= 2) break;
        end
        checks++;
        if (q[0].size() != 2) begin failures++; $display("FAIL rstmid_progress got=%0d exp=2", q[0].size()); end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({wr[0], df[0], busy_v[0], done_v[0]} !== 11'd0) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=0", {wr[0], df[0], busy_v[0], done_v[0]});
        end
        clear_logs();
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        checks++;
        if (q[0].size() + q[1].size() + q[2].size() + dn[0].size() + dn[1].size() + dn[2].size() != 0) begin
            failures++;
            $display("FAIL rstmid_quiet got=%0d/%0d exp=0/0", q[0].size(), dn[0].size());
        end
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_hex();
        test_stall();
        test_enviar_ignored();
        test_wide();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
